// File: rtl/counter_access_arbiter_if.sv
// Bus bundle between the user_project top level and the counter access arbiter:
// Wishbone slave, logic-analyzer write path and counter datapath hooks.
interface counter_access_arbiter_if #(
   parameter int unsigned BITS = 30
);
   logic            wbs_cyc_i;
   logic            wbs_stb_i;
   logic            wbs_we_i;
   logic [3:0]      wbs_sel_i;
   logic [31:0]     wbs_adr_i;
   logic [31:0]     wbs_dat_i;
   logic            wbs_ack_o;
   logic [31:0]     wbs_dat_o;
   logic            la_req_i;
   logic [BITS-1:0] la_mask_i;
   logic [BITS-1:0] la_data_i;
   logic            la_gnt_o;
   logic [BITS-1:0] cnt_i;
   logic            cnt_wr_o;
   logic [BITS-1:0] cnt_wr_mask_o;
   logic [BITS-1:0] cnt_wr_data_o;
   logic            cnt_hold_o;
   logic            busy_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  la_req_i, la_mask_i, la_data_i, cnt_i,
      output wbs_ack_o, wbs_dat_o, la_gnt_o,
      output cnt_wr_o, cnt_wr_mask_o, cnt_wr_data_o, cnt_hold_o, busy_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output la_req_i, la_mask_i, la_data_i, cnt_i,
      input  wbs_ack_o, wbs_dat_o, la_gnt_o,
      input  cnt_wr_o, cnt_wr_mask_o, cnt_wr_data_o, cnt_hold_o, busy_o
   );
endinterface

// File: rtl/counter_access_arbiter.sv
// Shares the counter's single write port and read path between Wishbone and the
// logic-analyzer write path; one access at a time, counting frozen while busy.
module counter_access_arbiter #(
   parameter int unsigned BITS        = 30,
   parameter logic [31:0] COUNT_ADDR  = 32'h3000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                     wb_clk_i,
   input logic                     wb_rst_n_i,
   counter_access_arbiter_if.slave bus
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WB_WAIT = 3'd1;
   localparam logic [2:0] WB_XFER = 3'd2;
   localparam logic [2:0] WB_ACK  = 3'd3;
   localparam logic [2:0] LA_XFER = 3'd4;

   localparam logic GRANT_WB = 1'b0;
   localparam logic GRANT_LA = 1'b1;

   logic [2:0]      state;
   logic            last_grant;
   logic [2:0]      wait_cnt;
   logic            cap_we;
   logic            cap_hit;
   logic [3:0]      cap_sel;
   logic [BITS-1:0] cap_dat;
   logic [BITS-1:0] la_mask_q;
   logic [BITS-1:0] la_data_q;
   logic            ack_q;
   logic [31:0]     rdata_q;

   logic            wb_req;
   logic            addr_hit;
   logic            grant_wb;
   logic            grant_la;
   logic [BITS-1:0] wb_mask;

   assign wb_req   = bus.wbs_cyc_i & bus.wbs_stb_i;
   assign addr_hit = (bus.wbs_adr_i == COUNT_ADDR);

   // On a tie the requester that did not win last time goes first.
   assign grant_wb = wb_req & (~bus.la_req_i | (last_grant == GRANT_LA));
   assign grant_la = bus.la_req_i & ~grant_wb;

   for (genvar i = 0; i < BITS; i++) begin : g_sel_mask
      assign wb_mask[i] = cap_sel[i / 8];
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state      <= IDLE;
         last_grant <= GRANT_LA;
         wait_cnt   <= '0;
         cap_we     <= 1'b0;
         cap_hit    <= 1'b0;
         cap_sel    <= '0;
         cap_dat    <= '0;
         la_mask_q  <= '0;
         la_data_q  <= '0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         // NOTE: non-blocking throughout so every register sees pre-edge values.
         ack_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_wb) begin
                  last_grant <= GRANT_WB;
                  cap_we     <= bus.wbs_we_i;
                  cap_hit    <= addr_hit;
                  cap_sel    <= bus.wbs_sel_i;
                  cap_dat    <= bus.wbs_dat_i[BITS-1:0];
                  if (WAIT_STATES > 0) begin
                     state    <= WB_WAIT;
                     wait_cnt <= 3'(WAIT_STATES);
                  end else begin
                     state <= WB_XFER;
                  end
               end else if (grant_la) begin
                  last_grant <= GRANT_LA;
                  la_mask_q  <= bus.la_mask_i;
                  la_data_q  <= bus.la_data_i;
                  state      <= LA_XFER;
               end
            end
            WB_WAIT: begin
               if (!bus.wbs_cyc_i) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
               end else if (wait_cnt == 3'd1) begin
                  state    <= WB_XFER;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            WB_XFER: begin
               state <= WB_ACK;
               ack_q <= 1'b1;
               if (!cap_we) rdata_q <= cap_hit ? 32'(bus.cnt_i) : 32'h0;
            end
            WB_ACK:  state <= IDLE;
            LA_XFER: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves these undriven (no latches).
      bus.cnt_wr_o      = 1'b0;
      bus.cnt_wr_mask_o = '0;
      bus.cnt_wr_data_o = '0;
      if (state == WB_XFER && cap_we && cap_hit) begin
         bus.cnt_wr_o      = 1'b1;
         bus.cnt_wr_mask_o = wb_mask;
         bus.cnt_wr_data_o = cap_dat;
      end else if (state == LA_XFER) begin
         bus.cnt_wr_o      = 1'b1;
         bus.cnt_wr_mask_o = la_mask_q;
         bus.cnt_wr_data_o = la_data_q;
      end
   end

   assign bus.wbs_ack_o  = ack_q;
   assign bus.wbs_dat_o  = rdata_q;
   assign bus.la_gnt_o   = (state == LA_XFER);
   assign bus.busy_o     = (state != IDLE);
   assign bus.cnt_hold_o = (state != IDLE);
endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench: three arbiters (WAIT_STATES 0, 2, 3) share one stimulus stream;
// each scenario checks the instance whose timing it targets.
module tb_counter_access_arbiter;
   localparam int unsigned BITS = 30;
   localparam logic [31:0] ADDR = 32'h3000_0000;
   localparam int D0 = 0;   // WAIT_STATES = 0
   localparam int D2 = 1;   // WAIT_STATES = 2
   localparam int D3 = 2;   // WAIT_STATES = 3

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cyc, stb, we, la_req;
   logic [3:0]      sel;
   logic [31:0]     adr, dat;
   logic [BITS-1:0] la_mask, la_data, cnt;

   logic            ack [3];
   logic            wr [3];
   logic            gnt [3];
   logic            hold [3];
   logic            busy [3];
   logic [31:0]     rdat [3];
   logic [BITS-1:0] wmask [3];
   logic [BITS-1:0] wdata [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
      counter_access_arbiter_if #(.BITS(BITS)) bus ();
      counter_access_arbiter #(
         .BITS(BITS), .COUNT_ADDR(ADDR), .WAIT_STATES(WS)
      ) u_dut (
         .wb_clk_i  (clk),
         .wb_rst_n_i(rst_n),
         .bus       (bus.slave)
      );
      assign bus.wbs_cyc_i = cyc;
      assign bus.wbs_stb_i = stb;
      assign bus.wbs_we_i  = we;
      assign bus.wbs_sel_i = sel;
      assign bus.wbs_adr_i = adr;
      assign bus.wbs_dat_i = dat;
      assign bus.la_req_i  = la_req;
      assign bus.la_mask_i = la_mask;
      assign bus.la_data_i = la_data;
      assign bus.cnt_i     = cnt;
      assign ack[g]   = bus.wbs_ack_o;
      assign rdat[g]  = bus.wbs_dat_o;
      assign gnt[g]   = bus.la_gnt_o;
      assign wr[g]    = bus.cnt_wr_o;
      assign wmask[g] = bus.cnt_wr_mask_o;
      assign wdata[g] = bus.cnt_wr_data_o;
      assign hold[g]  = bus.cnt_hold_o;
      assign busy[g]  = bus.busy_o;
   end

   typedef struct {
      string           name;
      logic            we;
      logic [3:0]      sel;
      logic [31:0]     adr;
      logic [31:0]     dat;
      logic [BITS-1:0] cnt;
      logic            exp_wr;
      logic [BITS-1:0] exp_mask;
      logic [BITS-1:0] exp_data;
      logic [31:0]     exp_rdat;
   } vec_t;

   vec_t vecs [9];

   function automatic vec_t mk(input string n, input logic w, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [BITS-1:0] c, input logic ew,
                               input logic [BITS-1:0] em, input logic [BITS-1:0] ed,
                               input logic [31:0] er);
      vec_t v;
      v.name = n; v.we = w; v.sel = s; v.adr = a; v.dat = d; v.cnt = c;
      v.exp_wr = ew; v.exp_mask = em; v.exp_data = ed; v.exp_rdat = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_io(input string tag, input int d, input logic e_busy,
                            input logic e_wr, input logic e_ack, input logic e_gnt);
      check({tag, "_busy"}, 32'(busy[d]), 32'(e_busy));
      check({tag, "_hold"}, 32'(hold[d]), 32'(e_busy));
      check({tag, "_wr"},   32'(wr[d]),   32'(e_wr));
      check({tag, "_ack"},  32'(ack[d]),  32'(e_ack));
      check({tag, "_gnt"},  32'(gnt[d]),  32'(e_gnt));
   endtask

   task automatic expect_wr(input string tag, input int d,
                            input logic [BITS-1:0] m, input logic [BITS-1:0] v);
      check({tag, "_mask"}, 32'(wmask[d]), 32'(m));
      check({tag, "_data"}, 32'(wdata[d]), 32'(v));
   endtask

   task automatic idle_inputs();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
      la_req = 1'b0; la_mask = '0; la_data = '0; cnt = '0;
   endtask

   // Leaves the bench just after edge 0; requests driven now are sampled at edge 1.
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Advance to the sampling point after the next active edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_wb(input logic w, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
   endtask

   initial begin
      idle_inputs();

      vecs[0] = mk("wr_lo16", 1'b1, 4'b0011, ADDR, 32'hFFFF_ABCD, 30'h0,
                   1'b1, 30'h0000_FFFF, 30'h3FFF_ABCD, 32'h0);
      vecs[1] = mk("wr_all", 1'b1, 4'b1111, ADDR, 32'h1234_5678, 30'h0,
                   1'b1, 30'h3FFF_FFFF, 30'h1234_5678, 32'h0);
      vecs[2] = mk("wr_top", 1'b1, 4'b1000, ADDR, 32'hA000_0001, 30'h0,
                   1'b1, 30'h3F00_0000, 30'h2000_0001, 32'h0);
      vecs[3] = mk("wr_sel0", 1'b1, 4'b0000, ADDR, 32'h0000_00FF, 30'h0,
                   1'b1, 30'h0, 30'h0000_00FF, 32'h0);
      vecs[4] = mk("rd_hit", 1'b0, 4'b1111, ADDR, 32'h0, 30'h0ABC_DEF0,
                   1'b0, 30'h0, 30'h0, 32'h0ABC_DEF0);
      vecs[5] = mk("wr_miss", 1'b1, 4'b1111, ADDR + 32'd4, 32'hFFFF_FFFF, 30'h0,
                   1'b0, 30'h0, 30'h0, 32'h0ABC_DEF0);
      vecs[6] = mk("rd_miss", 1'b0, 4'b1111, ADDR + 32'd4, 32'h0, 30'h3FFF_FFFF,
                   1'b0, 30'h0, 30'h0, 32'h0);
      vecs[7] = mk("rd_max", 1'b0, 4'b1111, ADDR, 32'h0, 30'h3FFF_FFFF,
                   1'b0, 30'h0, 30'h0, 32'h3FFF_FFFF);
      vecs[8] = mk("wr_b2", 1'b1, 4'b0100, ADDR, 32'h00FF_0000, 30'h0,
                   1'b1, 30'h00FF_0000, 30'h00FF_0000, 32'h3FFF_FFFF);

      // Reset state of every instance.
      do_reset();
      for (int d = 0; d < 3; d++) begin
         expect_io("rst", d, 1'b0, 1'b0, 1'b0, 1'b0);
         expect_wr("rst", d, '0, '0);
         check("rst_rdat", rdat[d], 32'h0);
      end

      // Single accesses, zero wait states: XFER after edge 1, ACK after edge 2.
      for (int i = 0; i < 9; i++) begin
         drive_wb(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat);
         cnt = vecs[i].cnt;
         step();
         expect_io({vecs[i].name, "_x"}, D0, 1'b1, vecs[i].exp_wr, 1'b0, 1'b0);
         expect_wr({vecs[i].name, "_x"}, D0, vecs[i].exp_mask, vecs[i].exp_data);
         step();
         expect_io({vecs[i].name, "_a"}, D0, 1'b1, 1'b0, 1'b1, 1'b0);
         check({vecs[i].name, "_rdat"}, rdat[D0], vecs[i].exp_rdat);
         cyc = 1'b0; stb = 1'b0;
         step();
         expect_io({vecs[i].name, "_i"}, D0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Read with two wait states: hold from edge 1 through the ack after edge 4.
      do_reset();
      drive_wb(1'b0, 4'b1111, ADDR, 32'h0);
      cnt = 30'h1234_5678;
      for (int e = 1; e <= 6; e++) begin
         step();
         check($sformatf("ws2_hold_e%0d", e), 32'(hold[D2]), 32'(e <= 4));
         check($sformatf("ws2_ack_e%0d", e),  32'(ack[D2]),  32'(e == 4));
         check($sformatf("ws2_wr_e%0d", e),   32'(wr[D2]),   32'h0);
         if (e == 4) begin
            check("ws2_rdat", rdat[D2], 32'h1234_5678);
            cyc = 1'b0; stb = 1'b0;
         end
      end

      // Reset in the middle of a three-wait-state write abandons it.
      do_reset();
      drive_wb(1'b1, 4'b1111, ADDR, 32'h3FFF_FFFF);
      step();
      check("rstmid_busy_e1", 32'(busy[D3]), 32'h1);
      step();
      check("rstmid_busy_e2", 32'(busy[D3]), 32'h1);
      #2;
      rst_n = 1'b0;
      cyc = 1'b0; stb = 1'b0;
      #1;
      expect_io("rstmid", D3, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_wr("rstmid", D3, '0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         check($sformatf("post_rst_quiet_%0d", c), {30'h0, wr[D3], ack[D3]}, 32'h0);
      end

      // First conflict after reset goes to Wishbone, then LA.
      drive_wb(1'b1, 4'b1111, ADDR, 32'h0000_0123);
      la_req = 1'b1; la_mask = 30'h3FFF_FFFF; la_data = 30'h0000_0321;
      step();
      expect_io("rst_cf_e1", D3, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); step(); step();
      expect_io("rst_cf_e4", D3, 1'b1, 1'b1, 1'b0, 1'b0);
      expect_wr("rst_cf_e4", D3, 30'h3FFF_FFFF, 30'h0000_0123);
      step();
      expect_io("rst_cf_e5", D3, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc = 1'b0; stb = 1'b0;
      step();
      expect_io("rst_cf_e6", D3, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expect_io("rst_cf_e7", D3, 1'b1, 1'b1, 1'b0, 1'b1);
      expect_wr("rst_cf_e7", D3, 30'h3FFF_FFFF, 30'h0000_0321);
      la_req = 1'b0;
      step();
      expect_io("rst_cf_e8", D3, 1'b0, 1'b0, 1'b0, 1'b0);

      // Continuous WB traffic against a held LA request alternates grants.
      do_reset();
      drive_wb(1'b1, 4'b1111, ADDR, 32'h0000_0055);
      la_req = 1'b1; la_mask = 30'h3FF0_000F; la_data = 30'h1555_5555;
      step();
      expect_io("rr_e1", D0, 1'b1, 1'b1, 1'b0, 1'b0);
      expect_wr("rr_e1", D0, 30'h3FFF_FFFF, 30'h0000_0055);
      step();
      expect_io("rr_e2", D0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      expect_io("rr_e3", D0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expect_io("rr_e4", D0, 1'b1, 1'b1, 1'b0, 1'b1);
      expect_wr("rr_e4", D0, 30'h3FF0_000F, 30'h1555_5555);
      la_mask = 30'h0000_FFFF; la_data = 30'h0AAA_AAAA;
      step();
      expect_io("rr_e5", D0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_wr("rr_e5", D0, '0, '0);
      step();
      expect_io("rr_e6", D0, 1'b1, 1'b1, 1'b0, 1'b0);
      expect_wr("rr_e6", D0, 30'h3FFF_FFFF, 30'h0000_0055);
      step();
      expect_io("rr_e7", D0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc = 1'b0; stb = 1'b0;
      step();
      expect_io("rr_e8", D0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expect_io("rr_e9", D0, 1'b1, 1'b1, 1'b0, 1'b1);
      expect_wr("rr_e9", D0, 30'h0000_FFFF, 30'h0AAA_AAAA);
      la_req = 1'b0;
      step();
      expect_io("rr_e10", D0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expect_io("rr_e11", D0, 1'b0, 1'b0, 1'b0, 1'b0);

      // cyc dropped in the second wait cycle; pending zero-mask LA write goes next.
      do_reset();
      drive_wb(1'b1, 4'b1111, ADDR, 32'h0000_0777);
      la_req = 1'b1; la_mask = '0; la_data = 30'h3FFF_FFFF;
      step();
      expect_io("abort_e1", D3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      expect_io("abort_e2", D3, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc = 1'b0; stb = 1'b0;
      step();
      expect_io("abort_e3", D3, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expect_io("abort_e4", D3, 1'b1, 1'b1, 1'b0, 1'b1);
      expect_wr("abort_e4", D3, 30'h0, 30'h3FFF_FFFF);
      la_req = 1'b0;
      for (int e = 5; e <= 8; e++) begin
         step();
         expect_io($sformatf("abort_e%0d", e), D3, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/counter_access_arbiter.md
Name: counter_access_arbiter

Overview:
Owns the single write port and the read path of the user-area BITS-wide counter, and shares them between the Wishbone slave and the logic-analyzer (LA) write path. Accesses are serialised through a small FSM with round-robin arbitration and programmable Wishbone wait states. While an access is in flight, counting is held so that a write never races an increment. Sits between the user_project top-level buses and the counter datapath.

Parameters:
BITS, 30, counter width (1..32)
COUNT_ADDR, 32'h3000_0000, Wishbone word address decoded as the counter register
WAIT_STATES, 0, extra Wishbone cycles inserted before the transfer (0..7)

Ports:
wb_clk_i  input  1  single clock
wb_rst_n_i  input  1  asynchronous active-low reset
wbs_cyc_i  input  1  Wishbone cycle
wbs_stb_i  input  1  Wishbone strobe
wbs_we_i  input  1  1 = write
wbs_sel_i  input  4  byte selects
wbs_adr_i  input  32  address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  registered acknowledge, one-cycle pulse
wbs_dat_o  output  32  read data, zero-extended counter value
la_req_i  input  1  LA write request (level, held until la_gnt_o)
la_mask_i  input  BITS  per-bit LA write enable
la_data_i  input  BITS  LA write data
la_gnt_o  output  1  one-cycle grant pulse; LA write performed this cycle
cnt_i  input  BITS  current counter value
cnt_wr_o  output  1  counter write strobe
cnt_wr_mask_o  output  BITS  per-bit write enable for cnt_wr_o
cnt_wr_data_o  output  BITS  write data for cnt_wr_o
cnt_hold_o  output  1  freeze counting
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, last_grant=LA, wait counter 0; every output 0. Reset mid-access abandons it: no write, no ack.
- wb_req = cyc & stb. Address hit = (wbs_adr_i == COUNT_ADDR).
- States: IDLE, WB_WAIT, WB_XFER, WB_ACK, LA_XFER.
- IDLE arbitration:
  - wb_req only -> WB.
  - la_req_i only -> LA.
  - Both -> the requester not in last_grant. last_grant updates on each grant.
- WB grant: capture we, sel, adr-hit and dat into registers. Go to WB_WAIT when WAIT_STATES>0 (counter=WAIT_STATES), otherwise to WB_XFER.
- WB_WAIT: decrement each cycle; at 1 go to WB_XFER. If cyc drops, abort to IDLE with no write and no ack.
- WB_XFER, write with hit: cnt_wr_o=1 for one cycle. cnt_wr_data_o = captured dat[BITS-1:0]. cnt_wr_mask_o bit i = sel[i/8]. Data bits >= BITS are ignored.
- WB_XFER, read with hit: wbs_dat_o <= {zeros, cnt_i}.
- WB_XFER, miss: no write; read data = 0.
- WB_ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
- wbs_dat_o holds its value until the next read transfer.
- WB latency (IDLE sampling edge = edge 0): ack is high during the cycle following edge WAIT_STATES+2.
- LA grant: IDLE -> LA_XFER. In LA_XFER: cnt_wr_o=1, cnt_wr_mask_o=la_mask_i, cnt_wr_data_o=la_data_i (sampled at grant), la_gnt_o=1; then IDLE. An all-zero mask is still granted (write with mask 0).
- la_req_i still high after its grant is treated as a new request.
- cnt_wr_o is 0 outside WB_XFER/LA_XFER; mask/data outputs are 0 when cnt_wr_o=0.
- cnt_hold_o = busy_o = (state != IDLE).
- Back-to-back: the FSM always passes through IDLE between grants. Worst-case LA wait under continuous WB traffic is one WB access.

Test Plan:
- Reset: pulse wb_rst_n_i low mid-WB_WAIT (WAIT_STATES=3) -> all outputs 0 immediately; no ack or write after release; first conflict is granted to WB.
- WB write at COUNT_ADDR, sel=4'b0011, dat=32'hFFFF_ABCD, WAIT_STATES=0 -> one cnt_wr_o pulse, mask=30'h0000_FFFF, data=30'h3FFF_ABCD; ack is high during the cycle after edge 2.
- WB read with cnt_i=30'h1234_5678 and WAIT_STATES=2 -> wbs_dat_o=32'h1234_5678, ack after edge 4; cnt_hold_o high from edge 1 through the ack cycle.
- WB miss (adr=COUNT_ADDR+4), write -> ack given, cnt_wr_o never asserts; a following read miss returns 0.
- Simultaneous wb_req and la_req_i from reset -> WB served first, LA_XFER immediately after IDLE with la_gnt_o pulse, mask/data equal to LA inputs; repeating the conflict serves LA first.
- WAIT_STATES=3, cyc dropped in the second wait cycle -> return to IDLE, no cnt_wr_o, no ack; a pending la_req_i is granted next.
